// File: rtl/usb_rx_param.sv
// USB 1.1 full-speed receiver: synchroniser, NRZI decode, bit unstuffing, SYNC/PID check,
// byte assembly into a first-word fall-through FIFO with occupancy and overflow reporting.
module usb_rx_param #(
  parameter int CLKS_PER_BIT = 8,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic                             d_plus,
  input  logic                             d_minus,
  input  logic                             r_enable,
  output logic [7:0]                       r_data,
  output logic                             empty,
  output logic                             full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  count,
  output logic                             rcving,
  output logic                             r_error,
  output logic                             overflow,
  output logic [3:0]                       PID
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic [TW-1:0] SAMPLE_AT = TW'(CLKS_PER_BIT/2);
  localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT-1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SYNC, ST_PID, ST_DATA, ST_EOP_WAIT, ST_ERROR
  } state_t;

  state_t        state;
  logic          dp_meta, dp_s, dm_meta, dm_s, dp_prev;
  logic [TW-1:0] timer;
  logic [TW-1:0] j_cnt;
  logic          prev_nrzi;
  logic [2:0]    ones;
  logic [2:0]    bit_cnt;
  logic [6:0]    shreg;
  logic          push_req;
  logic [7:0]    push_byte;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [CW-1:0] wptr, rptr, fill;
  logic          t_empty, t_full, do_push, do_pop, ov_clr;

  logic dp_edge, fall, sample, se0, j_line, dec_bit, in_pkt;
  logic se0_hit, eop_ok, stuff_err, accept, byte_done, pid_ok, to_error;
  logic [7:0] next_byte;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_meta <= 1'b0;
      dp_s    <= 1'b0;
      dm_meta <= 1'b0;
      dm_s    <= 1'b0;
      dp_prev <= 1'b0;
    end else begin
      dp_meta <= d_plus;
      dp_s    <= dp_meta;
      dm_meta <= d_minus;
      dm_s    <= dm_meta;
      dp_prev <= dp_s;
    end
  end

  // Bit timer re-aligns to every d_plus transition so sampling stays mid-bit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      timer <= '0;
    else if (dp_edge || timer == LAST_TICK)
      timer <= '0;
    else
      timer <= timer + TW'(1);
  end

  assign dp_edge   = dp_s ^ dp_prev;
  assign fall      = dp_prev & ~dp_s;
  assign sample    = (timer == SAMPLE_AT);
  assign se0       = ~dp_s & ~dm_s;
  assign j_line    = dp_s & ~dm_s;
  assign dec_bit   = (dp_s == prev_nrzi);
  assign next_byte = {dec_bit, shreg};
  assign in_pkt    = (state == ST_SYNC) || (state == ST_PID) || (state == ST_DATA);
  assign se0_hit   = in_pkt && sample && se0;
  assign eop_ok    = se0_hit && (state == ST_DATA) && (bit_cnt == 3'd0);
  assign stuff_err = in_pkt && sample && !se0 && (ones == 3'd6) && dec_bit;
  assign accept    = in_pkt && sample && !se0 && (ones != 3'd6);
  assign byte_done = accept && (bit_cnt == 3'd7);
  assign pid_ok    = (next_byte[7:4] == ~next_byte[3:0]);
  assign to_error  = (se0_hit && !eop_ok) || stuff_err ||
                     (byte_done && (state == ST_SYNC) && (next_byte != 8'h80)) ||
                     (byte_done && (state == ST_PID) && !pid_ok);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= ST_IDLE;
      rcving    <= 1'b0;
      r_error   <= 1'b0;
      PID       <= 4'h0;
      prev_nrzi <= 1'b0;
      ones      <= 3'd0;
      bit_cnt   <= 3'd0;
      shreg     <= 7'd0;
      j_cnt     <= '0;
      push_req  <= 1'b0;
      push_byte <= 8'h00;
    end else begin
      push_req <= 1'b0;
      if (to_error) begin
        state   <= ST_ERROR;
        r_error <= 1'b1;
        j_cnt   <= '0;
      end else begin
        // A bit following six 1s is a stuff bit: consumed but never shifted in.
        if (in_pkt && sample && !se0) begin
          prev_nrzi <= dp_s;
          if (ones == 3'd6) begin
            ones <= 3'd0;
          end else begin
            ones    <= dec_bit ? ones + 3'd1 : 3'd0;
            shreg   <= next_byte[7:1];
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        case (state)
          ST_IDLE: begin
            if (fall) begin
              state     <= ST_SYNC;
              rcving    <= 1'b1;
              r_error   <= 1'b0;
              prev_nrzi <= 1'b1;
              ones      <= 3'd0;
              bit_cnt   <= 3'd0;
            end
          end
          ST_SYNC: if (byte_done) state <= ST_PID;
          ST_PID: begin
            if (byte_done) begin
              PID   <= next_byte[3:0];
              state <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (eop_ok) begin
              state <= ST_EOP_WAIT;
            end else if (byte_done) begin
              push_req  <= 1'b1;
              push_byte <= next_byte;
            end
          end
          ST_EOP_WAIT: begin
            if (sample && j_line) begin
              state  <= ST_IDLE;
              rcving <= 1'b0;
            end
          end
          ST_ERROR: begin
            if (!j_line) begin
              j_cnt <= '0;
            end else if (j_cnt == LAST_TICK) begin
              state  <= ST_IDLE;
              rcving <= 1'b0;
            end else begin
              j_cnt <= j_cnt + TW'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign fill    = wptr - rptr;
  assign t_empty = (wptr == rptr);
  assign t_full  = (fill == CW'(FIFO_DEPTH));
  assign do_pop  = r_enable && !t_empty;
  assign do_push = push_req && (!t_full || do_pop);
  assign ov_clr  = (state == ST_IDLE) && fall;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_byte;
  end

  // Flag/data outputs are registered from the live pointers, hence one extra cycle of lag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      r_data   <= 8'h00;
    end else begin
      if (do_push) wptr <= wptr + CW'(1);
      if (do_pop)  rptr <= rptr + CW'(1);
      if (ov_clr) overflow <= 1'b0;
      if (push_req && !do_push) overflow <= 1'b1;
      count  <= fill;
      empty  <= t_empty;
      full   <= t_full;
      r_data <= mem[rptr[AW-1:0]];
    end
  end
endmodule

// File: tb/tb_usb_rx_param.sv
// Bench for usb_rx_param: line-level packet encoder, directed vector table, and randomized
// packets checked against a queue-based model of the receive FIFO and status flags.
module tb_usb_rx_param;
  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       n_rst, d_plus, d_minus, r_enable;
  logic [7:0] r_data;
  logic       empty, full, rcving, r_error, overflow;
  logic [2:0] count;
  logic [3:0] PID;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0]  pid_byte;
    logic [39:0] data;
    int          n_bytes;
    int          extra_bits;
    logic [7:0]  extra_pat;
    bit          bad_stuff;
    logic [3:0]  exp_pid;
    bit          exp_err;
    int          exp_count;
    bit          exp_ovf;
  } vec_t;

  always #5 clk = ~clk;

  usb_rx_param #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .n_rst(n_rst), .d_plus(d_plus), .d_minus(d_minus), .r_enable(r_enable),
    .r_data(r_data), .empty(empty), .full(full), .count(count), .rcving(rcving),
    .r_error(r_error), .overflow(overflow), .PID(PID)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_level(input logic dp, input logic dm, input int bits);
    d_plus  = dp;
    d_minus = dm;
    repeat (bits * CPB) @(negedge clk);
  endtask

  // Serialise SYNC, PID, data and trailing bits LSB-first, stuff after six 1s, NRZI-encode, then EOP.
  task automatic apply_stimulus(input logic [7:0] pid_byte, input logic [39:0] data, input int n_bytes,
                                input int extra_bits, input logic [7:0] extra_pat, input bit bad_stuff);
    bit         raw[$];
    bit         level;
    bit         corrupt;
    bit         stuff;
    int         ones;
    logic [7:0] sync_byte;
    sync_byte = 8'h80;
    for (int i = 0; i < 8; i++) raw.push_back(sync_byte[i]);
    for (int i = 0; i < 8; i++) raw.push_back(pid_byte[i]);
    for (int b = 0; b < n_bytes; b++)
      for (int i = 0; i < 8; i++) raw.push_back(data[b*8+i]);
    for (int i = 0; i < extra_bits; i++) raw.push_back(extra_pat[i]);
    level   = 1'b1;
    ones    = 0;
    corrupt = bad_stuff;
    foreach (raw[k]) begin
      if (!raw[k]) level = ~level;
      drive_level(level, ~level, 1);
      ones = raw[k] ? ones + 1 : 0;
      if (ones == 6) begin
        stuff   = corrupt;
        corrupt = 1'b0;
        if (!stuff) level = ~level;
        drive_level(level, ~level, 1);
        ones = 0;
      end
    end
    drive_level(1'b0, 1'b0, 2);
    drive_level(1'b1, 1'b0, 5);
  endtask

  task automatic pop_one();
    @(negedge clk) r_enable = 1'b1;
    @(negedge clk) r_enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_status(input string tag, input logic [3:0] e_pid, input bit e_err,
                              input int e_count, input bit e_ovf);
    check_output({tag, " PID"}, PID, e_pid);
    check_output({tag, " r_error"}, r_error, e_err);
    check_output({tag, " count"}, count, e_count);
    check_output({tag, " overflow"}, overflow, e_ovf);
    check_output({tag, " empty"}, empty, (e_count == 0));
    check_output({tag, " full"}, full, (e_count == DEPTH));
    check_output({tag, " rcving"}, rcving, 1'b0);
  endtask

  vec_t       tbl[7];
  logic [7:0] model_q[$];
  logic [3:0] model_pid;

  initial begin
    n_rst = 1'b0; d_plus = 1'b1; d_minus = 1'b0; r_enable = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset empty", empty, 1'b1);
    check_output("reset count", count, 0);
    check_output("reset PID", PID, 0);
    check_output("reset r_data", r_data, 0);
    n_rst = 1'b1;
    drive_level(1'b1, 1'b0, 4);

    // Leave a byte and a PID behind, start another packet, then reset in the middle of it.
    apply_stimulus(8'hE1, 40'hA5, 1, 0, 8'h00, 1'b0);
    check_output("pre-reset count", count, 1);
    check_output("pre-reset PID", PID, 4'h1);
    drive_level(1'b0, 1'b1, 3);
    check_output("mid-packet rcving", rcving, 1'b1);
    n_rst = 1'b0;
    d_plus = 1'b1; d_minus = 1'b0;
    repeat (2) @(negedge clk);
    check_output("mid reset empty", empty, 1'b1);
    check_output("mid reset count", count, 0);
    check_output("mid reset rcving", rcving, 1'b0);
    check_output("mid reset r_error", r_error, 1'b0);
    check_output("mid reset overflow", overflow, 1'b0);
    check_output("mid reset PID", PID, 4'h0);
    n_rst = 1'b1;
    drive_level(1'b1, 1'b0, 5);
    check_output("post reset rcving", rcving, 1'b0);
    check_output("post reset count", count, 0);

    tbl[0] = '{pid_byte:8'hE1, data:40'hA5, n_bytes:1, extra_bits:0, extra_pat:8'h00, bad_stuff:1'b0,
               exp_pid:4'h1, exp_err:1'b0, exp_count:1, exp_ovf:1'b0};
    tbl[1] = '{pid_byte:8'h33, data:40'h0, n_bytes:0, extra_bits:0, extra_pat:8'h00, bad_stuff:1'b0,
               exp_pid:4'h1, exp_err:1'b1, exp_count:0, exp_ovf:1'b0};
    tbl[2] = '{pid_byte:8'hC3, data:40'hFF, n_bytes:1, extra_bits:0, extra_pat:8'h00, bad_stuff:1'b0,
               exp_pid:4'h3, exp_err:1'b0, exp_count:1, exp_ovf:1'b0};
    tbl[3] = '{pid_byte:8'hC3, data:40'hFF, n_bytes:1, extra_bits:0, extra_pat:8'h00, bad_stuff:1'b1,
               exp_pid:4'h3, exp_err:1'b1, exp_count:0, exp_ovf:1'b0};
    tbl[4] = '{pid_byte:8'hA5, data:40'h0, n_bytes:0, extra_bits:4, extra_pat:8'h0B, bad_stuff:1'b0,
               exp_pid:4'h5, exp_err:1'b1, exp_count:0, exp_ovf:1'b0};
    tbl[5] = '{pid_byte:8'hD2, data:40'h05_04_03_02_01, n_bytes:5, extra_bits:0, extra_pat:8'h00,
               bad_stuff:1'b0, exp_pid:4'h2, exp_err:1'b0, exp_count:4, exp_ovf:1'b1};
    tbl[6] = '{pid_byte:8'h69, data:40'h7E00, n_bytes:2, extra_bits:0, extra_pat:8'h00, bad_stuff:1'b0,
               exp_pid:4'h9, exp_err:1'b0, exp_count:2, exp_ovf:1'b0};

    for (int t = 0; t < 7; t++) begin
      apply_stimulus(tbl[t].pid_byte, tbl[t].data, tbl[t].n_bytes, tbl[t].extra_bits,
                     tbl[t].extra_pat, tbl[t].bad_stuff);
      check_status($sformatf("vec%0d", t), tbl[t].exp_pid, tbl[t].exp_err, tbl[t].exp_count, tbl[t].exp_ovf);
      for (int k = 0; k < tbl[t].exp_count; k++) begin
        check_output($sformatf("vec%0d r_data[%0d]", t, k), r_data, tbl[t].data[k*8 +: 8]);
        pop_one();
      end
      check_output($sformatf("vec%0d drained empty", t), empty, 1'b1);
    end

    pop_one();
    check_output("pop on empty count", count, 0);
    check_output("pop on empty empty", empty, 1'b1);

    model_pid = 4'h9;
    for (int p = 0; p < 20; p++) begin
      bit          valid, m_err, m_ovf;
      logic [3:0]  pn;
      logic [7:0]  pb;
      logic [39:0] d;
      int          nb, xb, nr;
      valid = ($urandom_range(0, 4) != 0);
      pn    = 4'($urandom);
      d     = {8'($urandom), 32'($urandom)};
      if (valid) begin
        pb = {~pn, pn};
        nb = $urandom_range(0, 5);
        xb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      end else begin
        do pb = 8'($urandom); while (pb[7:4] == ~pb[3:0]);
        nb = 0;
        xb = 0;
      end
      m_ovf = 1'b0;
      m_err = !valid;
      if (valid) begin
        model_pid = pn;
        for (int b = 0; b < nb; b++) begin
          if (model_q.size() < DEPTH) model_q.push_back(d[b*8 +: 8]);
          else m_ovf = 1'b1;
        end
        if (xb != 0) m_err = 1'b1;
      end
      apply_stimulus(pb, d, nb, xb, 8'($urandom), 1'b0);
      check_status($sformatf("rand%0d", p), model_pid, m_err, model_q.size(), m_ovf);
      nr = $urandom_range(0, model_q.size());
      for (int k = 0; k < nr; k++) begin
        check_output($sformatf("rand%0d r_data[%0d]", p, k), r_data, model_q.pop_front());
        pop_one();
      end
      check_output($sformatf("rand%0d count after reads", p), count, model_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
